dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
Two-requester arbiter and sequencer in front of the single-port DataMemory of the RV32I core. Port 0 is the core load/store unit. Port 1 is the test/loader master that preloads or inspects data memory. The block serialises word transactions from both ports, drives the MemRead/MemWrite/addr/write_data strobes for a fixed access time, captures read_data, and returns a one-cycle completion pulse to the owning requester.

Parameters:
ADDR_W, 32, address width for requesters and memory
DATA_W, 32, data width
MEM_LAT, 1, cycles the memory strobe is held; read_data is sampled on the last of them (legal 1..15)

Ports:
clk  in  1  system clock, rising edge
rst  in  1  synchronous active-high reset
m0_req  in  1  port 0 request, held until m0_done
m0_we  in  1  port 0: 1=write, 0=read
m0_addr  in  ADDR_W  port 0 byte address
m0_wdata  in  DATA_W  port 0 write data
m0_done  out  1  port 0 completion pulse
m0_err  out  1  port 0 misaligned flag, valid with m0_done
m0_rdata  out  DATA_W  port 0 read data, valid from m0_done, held until the next m0_done
m1_req, m1_we, m1_addr, m1_wdata, m1_done, m1_err, m1_rdata  same as port 0, for port 1
MemRead  out  1  memory read strobe
MemWrite  out  1  memory write strobe
addr  out  ADDR_W  memory address
write_data  out  DATA_W  memory write data
read_data  in  DATA_W  memory read data
busy  out  1  high in any state other than IDLE

Behaviour:
- Interface decision: one clock (clk); synchronous active-high reset (rst). All outputs are registered.
- Reset values: MemRead=0, MemWrite=0, addr=0, write_data=0, mX_done=0, mX_err=0, mX_rdata=0, busy=0, state=IDLE, last_gnt=1 (port 0 wins the first tie).
- FSM IDLE -> ACCESS -> DONE -> IDLE.
  - IDLE: samples the req lines only in this state.
    - Grant rule: if both req are high, grant the port != last_gnt; if one is high, grant it; if none, stay in IDLE.
    - On a grant: latch we/addr/wdata and the grant id, update last_gnt, load cnt=MEM_LAT-1.
  - IDLE with a misaligned address (addr[1:0]!=0): skip ACCESS and go straight to DONE with err=1. No memory strobe is driven and the rdata register is unchanged.
  - ACCESS: drive addr/write_data from the latched values. MemWrite=we and MemRead=~we, never both high. cnt decrements each cycle. When cnt==0: for a read, capture read_data into the granted port's rdata register; then go to DONE.
  - DONE: strobes low. Granted port's done=1 for exactly this cycle, with err valid. Return to IDLE.
- Latency: req high at edge N (in IDLE) -> done high in cycle N+MEM_LAT+1. A back-to-back transaction takes MEM_LAT+2 cycles.
- Requester rule: keep req and its fields stable until done is seen. Drop req on the edge where done=1, or keep req high to issue the next transaction. The arbiter ignores req in ACCESS and DONE, so there is no duplicate grant.
- Fairness: under continuous requests from both ports, grants alternate 0,1,0,1.
- Mid-transaction changes: a change on the non-granted port has no effect. A change on the granted port's fields is ignored because the values are latched.
- Reset mid-ACCESS: strobes are low on the next edge. The write may or may not have completed. No done pulse is issued.
- addr/write_data hold their last values after ACCESS (not cleared).

Decomposition:
- Shared package: state encoding (IDLE=2'd0, ACCESS=2'd1, DONE=2'd2), port id constants P_CORE=1'b0 and P_LOAD=1'b1, and the word-alignment mask.
- Sub-module rr_arb2: a 2-input round-robin grant with a last_gnt register. It is combinational plus one flop and is reused by a future instruction-memory arbiter.

Test Plan:
1. rst high for 2 cycles, then low -> all outputs 0 and busy=0; with no req, MemRead and MemWrite stay 0 for 10 cycles.
2. m0 write addr=4, wdata=100, then m0 read addr=4 (MEM_LAT=1) -> MemWrite=1 for one cycle with addr=4 and write_data=100; m0_done 2 cycles after req; m0_rdata=100; m0_err=0.
3. m0 and m1 req in the same cycle (m0 read addr=8, m1 write addr=12, wdata=300) -> m0 served first, m1 next; m1 done at cycle +5; a following m0 read of addr=12 returns 300.
4. Both ports hold req continuously for 8 transactions -> grant order 0,1,0,1,0,1,0,1; one done every 3 cycles; done never asserts on both ports in the same cycle.
5. m1 read addr=6 -> no MemRead/MemWrite pulse; m1_done with m1_err=1 one cycle after the grant; m1_rdata unchanged.
6. MEM_LAT=3: m0 write addr=8, wdata=200; assert rst during the 2nd ACCESS cycle -> strobes 0 next edge, no m0_done, state IDLE, busy=0; a new read completes normally.

Source files
------------

// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter slice: sequencer state
// encoding, requester port identifiers and the word-alignment helper.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

    // Sequencer states; the encoding is fixed so waveforms read the same
    // across every arbiter built on this package.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        DONE   = 2'd2
    } state_t;

    // Requester identifiers: port 0 is the core load/store unit, port 1 is
    // the test/loader master.
    localparam logic P_CORE = 1'b0;
    localparam logic P_LOAD = 1'b1;

    // Low address bits that must be zero for a word access.
    localparam logic [1:0] WORD_MASK = 2'b11;

    // True when a byte address does not point at a word boundary.
    function automatic logic is_misaligned(input logic [1:0] addr_lo);
        return (addr_lo & WORD_MASK) != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arbiter_rr_arb2.sv
// -----------------------------------------------------------------------------
// rr_arb2
// Two-input round-robin grant. The grant itself is combinational; a single
// last_gnt flop remembers who won the previous grant so that a tie goes to
// the other port. Written to be reused by the instruction-memory arbiter.
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   synchronous active-high reset (last_gnt -> P_LOAD so the
//                   core wins the first tie)
//   req[1:0]   in   request lines, bit i belongs to port i
//   take       in   the owner accepts the current grant this cycle
//   gnt_valid  out  at least one request is present
//   gnt_id     out  id of the port that would be granted now
// -----------------------------------------------------------------------------
module rr_arb2
    import dmem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       take,
    output logic       gnt_valid,
    output logic       gnt_id
);

    logic last_gnt;

    // A lone request wins outright; with both high the port that did not
    // win last time gets the grant, which makes grants alternate under load.
    always_comb begin
        gnt_valid = |req;
        gnt_id    = P_CORE;
        if (req[0] && req[1]) begin
            gnt_id = ~last_gnt;
        end else if (req[1]) begin
            gnt_id = P_LOAD;
        end
    end

    // History only moves when the grant is actually consumed, so a request
    // that is merely visible while the owner is busy does not skew fairness.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_gnt <= P_LOAD;
        end else if (take && gnt_valid) begin
            last_gnt <= gnt_id;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Serialises word transactions from the core (port 0) and the loader (port 1)
// onto the single-port DataMemory. A grant latches the request fields, the
// memory strobe is held for MEM_LAT cycles, read_data is captured on the last
// of them and the owning port gets a one-cycle done pulse. Misaligned
// addresses skip the memory entirely and complete with err set.
//
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   mX_req/we/addr/wdata     request from port X, held until mX_done
//   mX_done                  one-cycle completion pulse for port X
//   mX_err                   misaligned flag, valid with mX_done
//   mX_rdata                 read data, held until the next mX_done
//   MemRead, MemWrite        memory strobes (never both high)
//   addr, write_data         memory address / write data (hold after access)
//   read_data                memory read data
//   busy                     sequencer is not in IDLE
// All outputs are registered.
// -----------------------------------------------------------------------------
module dmem_arbiter
    import dmem_arbiter_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_req,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [DATA_W-1:0] m0_wdata,
    output logic              m0_done,
    output logic              m0_err,
    output logic [DATA_W-1:0] m0_rdata,
    input  logic              m1_req,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [DATA_W-1:0] m1_wdata,
    output logic              m1_done,
    output logic              m1_err,
    output logic [DATA_W-1:0] m1_rdata,
    output logic              MemRead,
    output logic              MemWrite,
    output logic [ADDR_W-1:0] addr,
    output logic [DATA_W-1:0] write_data,
    input  logic [DATA_W-1:0] read_data,
    output logic              busy
);

    localparam int CNT_W = 4;

    state_t            state, state_nxt;
    logic              own_q, own_nxt;
    logic              we_q, we_nxt;
    logic [CNT_W-1:0]  cnt_q, cnt_nxt;
    logic [ADDR_W-1:0] addr_nxt;
    logic [DATA_W-1:0] wdata_nxt;
    logic              mem_rd_nxt, mem_wr_nxt;
    logic [1:0]        done_nxt, err_nxt;
    logic [DATA_W-1:0] rdata0_nxt, rdata1_nxt;
    logic              busy_nxt;

    logic              gnt_valid, gnt_id;
    logic              sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_wdata;

    // Requests are only consumed in IDLE, so the arbiter history advances
    // exactly once per transaction.
    rr_arb2 u_arb (
        .clk       (clk),
        .rst       (rst),
        .req       ({m1_req, m0_req}),
        .take      (state == IDLE),
        .gnt_valid (gnt_valid),
        .gnt_id    (gnt_id)
    );

    // Fields of whichever port the arbiter would grant this cycle.
    always_comb begin
        sel_we    = gnt_id ? m1_we    : m0_we;
        sel_addr  = gnt_id ? m1_addr  : m0_addr;
        sel_wdata = gnt_id ? m1_wdata : m0_wdata;
    end

    // Next-state and next-output logic. Because every output is a flop, the
    // values computed here are what the outputs show in the following cycle:
    // strobes are raised on the grant so they are visible for the first
    // ACCESS cycle, and dropped on the last ACCESS cycle so DONE sees them low.
    always_comb begin
        state_nxt  = state;
        own_nxt    = own_q;
        we_nxt     = we_q;
        cnt_nxt    = cnt_q;
        addr_nxt   = addr;
        wdata_nxt  = write_data;
        mem_rd_nxt = 1'b0;
        mem_wr_nxt = 1'b0;
        done_nxt   = 2'b00;
        err_nxt    = 2'b00;
        rdata0_nxt = m0_rdata;
        rdata1_nxt = m1_rdata;

        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    own_nxt = gnt_id;
                    we_nxt  = sel_we;
                    if (is_misaligned(sel_addr[1:0])) begin
                        // Bad address: complete immediately with err and
                        // leave memory and the rdata registers untouched.
                        state_nxt        = DONE;
                        done_nxt[gnt_id] = 1'b1;
                        err_nxt[gnt_id]  = 1'b1;
                    end else begin
                        state_nxt  = ACCESS;
                        addr_nxt   = sel_addr;
                        wdata_nxt  = sel_wdata;
                        cnt_nxt    = CNT_W'(MEM_LAT - 1);
                        mem_wr_nxt = sel_we;
                        mem_rd_nxt = ~sel_we;
                    end
                end
            end
            ACCESS: begin
                if (cnt_q == '0) begin
                    state_nxt       = DONE;
                    done_nxt[own_q] = 1'b1;
                    if (!we_q) begin
                        if (own_q == P_LOAD) begin
                            rdata1_nxt = read_data;
                        end else begin
                            rdata0_nxt = read_data;
                        end
                    end
                end else begin
                    cnt_nxt    = cnt_q - 4'd1;
                    mem_wr_nxt = we_q;
                    mem_rd_nxt = ~we_q;
                end
            end
            DONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase

        busy_nxt = (state_nxt != IDLE);
    end

    // State and output registers. Reset clears everything so an access cut
    // short by reset drops its strobes on the next edge and never reports done.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            own_q      <= P_CORE;
            we_q       <= 1'b0;
            cnt_q      <= '0;
            addr       <= '0;
            write_data <= '0;
            MemRead    <= 1'b0;
            MemWrite   <= 1'b0;
            m0_done    <= 1'b0;
            m1_done    <= 1'b0;
            m0_err     <= 1'b0;
            m1_err     <= 1'b0;
            m0_rdata   <= '0;
            m1_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            own_q      <= own_nxt;
            we_q       <= we_nxt;
            cnt_q      <= cnt_nxt;
            addr       <= addr_nxt;
            write_data <= wdata_nxt;
            MemRead    <= mem_rd_nxt;
            MemWrite   <= mem_wr_nxt;
            m0_done    <= done_nxt[0];
            m1_done    <= done_nxt[1];
            m0_err     <= err_nxt[0];
            m1_err     <= err_nxt[1];
            m0_rdata   <= rdata0_nxt;
            m1_rdata   <= rdata1_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Directed bench for dmem_arbiter. One instance uses MEM_LAT=1 for the main
// sequences; a second instance with MEM_LAT=3 is used for reset mid-access.
// Each instance talks to a small word memory model written on MemWrite.
// -----------------------------------------------------------------------------
module tb_dmem_arbiter;

    logic        clk;
    logic        rst;

    logic        m0_req, m0_we, m1_req, m1_we;
    logic [31:0] m0_addr, m0_wdata, m1_addr, m1_wdata;
    logic        m0_done, m0_err, m1_done, m1_err;
    logic [31:0] m0_rdata, m1_rdata;
    logic        MemRead, MemWrite, busy;
    logic [31:0] addr, write_data, read_data;

    logic        t_rst, t_req, t_we;
    logic [31:0] t_addr, t_wdata;
    logic        t_done, t_err, t_rd, t_wr, t_busy;
    logic [31:0] t_rdata, t_a, t_wd, t_read_data;
    logic        t1_req, t1_we;
    logic [31:0] t1_addr, t1_wdata;
    logic        t1_done, t1_err;
    logic [31:0] t1_rdata;

    logic [31:0] mem_a [0:63];
    logic [31:0] mem_b [0:63];

    int          checks = 0;
    int          passes = 0;
    int          wr_pulses = 0;
    int          rd_pulses = 0;
    logic [31:0] wr_addr = 0;
    logic [31:0] wr_data = 0;

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut (
        .clk(clk), .rst(rst),
        .m0_req(m0_req), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_done(m0_done), .m0_err(m0_err), .m0_rdata(m0_rdata),
        .m1_req(m1_req), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_done(m1_done), .m1_err(m1_err), .m1_rdata(m1_rdata),
        .MemRead(MemRead), .MemWrite(MemWrite), .addr(addr),
        .write_data(write_data), .read_data(read_data), .busy(busy)
    );

    dmem_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(3)) dut3 (
        .clk(clk), .rst(t_rst),
        .m0_req(t_req), .m0_we(t_we), .m0_addr(t_addr), .m0_wdata(t_wdata),
        .m0_done(t_done), .m0_err(t_err), .m0_rdata(t_rdata),
        .m1_req(t1_req), .m1_we(t1_we), .m1_addr(t1_addr), .m1_wdata(t1_wdata),
        .m1_done(t1_done), .m1_err(t1_err), .m1_rdata(t1_rdata),
        .MemRead(t_rd), .MemWrite(t_wr), .addr(t_a),
        .write_data(t_wd), .read_data(t_read_data), .busy(t_busy)
    );

    // Free-running clock, 10 time units per period.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Word memory models: combinational read, write on the rising edge.
    assign read_data   = mem_a[addr[7:2]];
    assign t_read_data = mem_b[t_a[7:2]];

    always @(posedge clk) begin
        if (MemWrite) mem_a[addr[7:2]] <= write_data;
        if (t_wr)     mem_b[t_a[7:2]]  <= t_wd;
    end

    // Strobe monitor sampled mid-cycle; tests look at the deltas.
    always @(negedge clk) begin
        if (MemWrite) begin
            wr_pulses <= wr_pulses + 1;
            wr_addr   <= addr;
            wr_data   <= write_data;
        end
        if (MemRead) rd_pulses <= rd_pulses + 1;
    end

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] act,
                               input logic [31:0] exp);
        checks++;
        if (act === exp) begin
            passes++;
        end else begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    // Issue one transaction on the main instance and wait for its done.
    // Called #1 after a rising edge; returns with done visible and req dropped.
    task automatic applyStimulus(input logic port, input logic we,
                                 input logic [31:0] a, input logic [31:0] d,
                                 output int lat, output logic err,
                                 output logic [31:0] rd);
        logic seen;
        if (port) begin
            m1_we = we; m1_addr = a; m1_wdata = d; m1_req = 1'b1;
        end else begin
            m0_we = we; m0_addr = a; m0_wdata = d; m0_req = 1'b1;
        end
        lat  = 0;
        seen = 1'b0;
        do begin
            @(posedge clk); #1;
            lat++;
            seen = port ? m1_done : m0_done;
        end while (!seen && lat < 40);
        if (!seen) checkOutput("done_timeout", 32'd0, 32'd1);
        err = port ? m1_err : m0_err;
        rd  = port ? m1_rdata : m0_rdata;
        if (port) m1_req = 1'b0;
        else      m0_req = 1'b0;
    endtask

    task automatic pulseReset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    int          lat0, lat1, w0, r0, n, cyc, prev_cyc, both_cnt, idle_strobes;
    logic        err0, err1;
    logic [31:0] rd0, rd1;

    initial begin
        rst = 1'b1; m0_req = 0; m0_we = 0; m0_addr = 0; m0_wdata = 0;
        m1_req = 0; m1_we = 0; m1_addr = 0; m1_wdata = 0;
        t_rst = 1'b1; t_req = 0; t_we = 0; t_addr = 0; t_wdata = 0;
        t1_req = 0; t1_we = 0; t1_addr = 0; t1_wdata = 0;

        // ---- 1: reset state and quiet idle ----
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        checkOutput("rst_MemRead",    MemRead,    0);
        checkOutput("rst_MemWrite",   MemWrite,   0);
        checkOutput("rst_addr",       addr,       0);
        checkOutput("rst_write_data", write_data, 0);
        checkOutput("rst_done",       {m0_done, m1_done}, 0);
        checkOutput("rst_err",        {m0_err, m1_err},   0);
        checkOutput("rst_m0_rdata",   m0_rdata,   0);
        checkOutput("rst_m1_rdata",   m1_rdata,   0);
        checkOutput("rst_busy",       busy,       0);
        idle_strobes = 0;
        repeat (10) begin
            @(posedge clk); #1;
            if (MemRead || MemWrite) idle_strobes++;
        end
        checkOutput("idle_strobes", idle_strobes, 0);

        // ---- 2: m0 write then read back ----
        w0 = wr_pulses; r0 = rd_pulses;
        applyStimulus(1'b0, 1'b1, 32'd4, 32'd100, lat0, err0, rd0);
        checkOutput("t2_wr_latency", lat0, 2);
        checkOutput("t2_wr_pulses",  wr_pulses - w0, 1);
        checkOutput("t2_wr_addr",    wr_addr, 32'd4);
        checkOutput("t2_wr_data",    wr_data, 32'd100);
        checkOutput("t2_wr_err",     err0, 0);
        @(posedge clk); #1;
        w0 = wr_pulses; r0 = rd_pulses;
        applyStimulus(1'b0, 1'b0, 32'd4, 32'd0, lat0, err0, rd0);
        checkOutput("t2_rd_latency", lat0, 2);
        checkOutput("t2_rd_data",    rd0, 32'd100);
        checkOutput("t2_rd_err",     err0, 0);
        checkOutput("t2_rd_pulses",  rd_pulses - r0, 1);
        checkOutput("t2_rd_nowrite", wr_pulses - w0, 0);
        @(posedge clk); #1;

        // ---- preload via loader port for tests 3 and 4 ----
        applyStimulus(1'b1, 1'b1, 32'd8,  32'd77,    lat1, err1, rd1);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b1, 32'd16, 32'h0000_00A0, lat1, err1, rd1);
        @(posedge clk); #1;
        applyStimulus(1'b1, 1'b1, 32'd20, 32'h0000_00B0, lat1, err1, rd1);
        @(posedge clk); #1;

        // ---- 3: simultaneous requests after reset, core wins the tie ----
        pulseReset();
        fork
            applyStimulus(1'b0, 1'b0, 32'd8,  32'd0,   lat0, err0, rd0);
            applyStimulus(1'b1, 1'b1, 32'd12, 32'd300, lat1, err1, rd1);
        join
        checkOutput("t3_m0_latency", lat0, 2);
        checkOutput("t3_m0_rdata",   rd0, 32'd77);
        checkOutput("t3_m1_latency", lat1, 5);
        @(posedge clk); #1;
        applyStimulus(1'b0, 1'b0, 32'd12, 32'd0, lat0, err0, rd0);
        checkOutput("t3_readback", rd0, 32'd300);
        @(posedge clk); #1;

        // ---- 4: continuous requests from both ports alternate ----
        pulseReset();
        m0_we = 0; m0_addr = 32'd16; m0_wdata = 0;
        m1_we = 0; m1_addr = 32'd20; m1_wdata = 0;
        m0_req = 1'b1; m1_req = 1'b1;
        n = 0; cyc = 0; prev_cyc = 0; both_cnt = 0;
        while (n < 8 && cyc < 80) begin
            @(posedge clk); #1;
            cyc++;
            if (m0_done && m1_done) both_cnt++;
            if (m0_done || m1_done) begin
                checkOutput($sformatf("t4_order_%0d", n), m1_done, n % 2);
                if (n > 0) checkOutput($sformatf("t4_gap_%0d", n), cyc - prev_cyc, 3);
                if (m0_done) checkOutput("t4_m0_rdata", m0_rdata, 32'h0000_00A0);
                else         checkOutput("t4_m1_rdata", m1_rdata, 32'h0000_00B0);
                prev_cyc = cyc;
                n++;
                if (n == 8) begin
                    m0_req = 1'b0; m1_req = 1'b0;
                end
            end
        end
        m0_req = 1'b0; m1_req = 1'b0;
        checkOutput("t4_count",     n, 8);
        checkOutput("t4_dual_done", both_cnt, 0);
        @(posedge clk); #1;

        // ---- 5: misaligned loader read ----
        w0 = wr_pulses; r0 = rd_pulses;
        applyStimulus(1'b1, 1'b0, 32'd6, 32'd0, lat1, err1, rd1);
        checkOutput("t5_latency",  lat1, 1);
        checkOutput("t5_err",      err1, 1);
        checkOutput("t5_rdata",    rd1, 32'h0000_00B0);
        checkOutput("t5_strobes",  (wr_pulses - w0) + (rd_pulses - r0), 0);
        @(posedge clk); #1;

        // ---- 6: MEM_LAT=3, reset during the second ACCESS cycle ----
        t_rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 t_rst = 1'b0;
        t_we = 1'b1; t_addr = 32'd8; t_wdata = 32'd200; t_req = 1'b1;
        @(posedge clk); #1;
        checkOutput("t6_wr_strobe", t_wr, 1);
        @(posedge clk); #1;
        t_rst = 1'b1; t_req = 1'b0;
        @(posedge clk); #1;
        checkOutput("t6_rst_strobes", {t_rd, t_wr}, 0);
        checkOutput("t6_rst_busy",    t_busy, 0);
        checkOutput("t6_rst_done",    t_done, 0);
        t_rst = 1'b0;
        n = 0;
        repeat (5) begin
            @(posedge clk); #1;
            if (t_done || t_busy) n++;
        end
        checkOutput("t6_no_done_idle", n, 0);
        t_we = 1'b0; t_req = 1'b1;
        lat0 = 0;
        do begin
            @(posedge clk); #1;
            lat0++;
        end while (!t_done && lat0 < 40);
        t_req = 1'b0;
        checkOutput("t6_rd_latency", lat0, 4);
        checkOutput("t6_rd_data",    t_rdata, 32'd200);
        checkOutput("t6_rd_err",     t_err, 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
